// File: rtl/pre_pc_fetch_if.sv
// Instruction-bus read channel between the prefetch stage (master) and the bus slave.
interface pre_pc_fetch_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [INST_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_addr,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/pre_pc_fetch.sv
// Prefetch stage: streams sequential instruction words from the bus into the ICache fill port.
// Optional PREPC_PERF_CNT_EN adds fill and redirect event counters.
module pre_pc_fetch #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] PC_INIT    = 64'h8000_0000,
  parameter int unsigned       FILL_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  pre_pc_fetch_if.master    bus,
  input  logic [ADDR_W-1:0] i_pc_in,
  input  logic              i_jump_flag,
  input  logic [ADDR_W-1:0] i_jump_addr,
  input  logic              i_cache_full,
  input  logic              i_cache_missing,
  output logic [ADDR_W-1:0] o_pre_pc_out,
  output logic [INST_W-1:0] o_inst_out,
`ifdef PREPC_PERF_CNT_EN
  output logic [31:0]       o_fill_cnt,
  output logic [31:0]       o_redirect_cnt,
`endif
  output logic              o_read_shake_hands
);

  localparam int unsigned CNT_W = $clog2(FILL_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pre_pc, w_pre_pc_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;

  logic [ADDR_W-1:0] r_pre_pc_out;
  logic [INST_W-1:0] r_inst_out;
  logic              r_rsh;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_base;
  logic              w_hs;
  logic              w_last;
  logic              w_fill;

  // Jump outranks a cache-miss refill; IDLE ignores both for its single cycle.
  assign w_redirect = (r_state != S_IDLE) && (i_jump_flag || i_cache_missing);
  assign w_target   = i_jump_flag ? i_jump_addr : i_pc_in;
  assign w_base     = {w_target[ADDR_W-1:2], 2'b00};
  assign w_hs       = bus.bus_req && bus.bus_gnt;
  assign w_last     = (r_word_cnt == CNT_W'(FILL_WORDS - 1));
  assign w_fill     = (r_state == S_WAIT) && bus.bus_rvalid && !w_redirect;

  assign bus.bus_req  = (r_state == S_REQ);
  assign bus.bus_addr = r_pre_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pre_pc_nxt   = r_pre_pc;
    w_word_cnt_nxt = r_word_cnt;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        // A grant in the redirect cycle leaves a stale read in flight to be drained.
        if (w_redirect)        w_state_nxt = w_hs ? S_DRAIN : S_REQ;
        else if (w_hs)         w_state_nxt = S_WAIT;
        else if (i_cache_full) w_state_nxt = S_FULL;
      end
      S_WAIT: begin
        if (w_redirect)
          w_state_nxt = bus.bus_rvalid ? S_REQ : S_DRAIN;
        else if (bus.bus_rvalid)
          w_state_nxt = (w_last || i_cache_full) ? S_FULL : S_REQ;
      end
      S_FULL: begin
        if (w_redirect) w_state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (bus.bus_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_redirect) begin
      w_pre_pc_nxt   = w_base;
      w_word_cnt_nxt = '0;
    end else if (w_fill) begin
      w_pre_pc_nxt   = r_pre_pc + ADDR_W'(4);
      w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pre_pc   <= PC_INIT;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre_pc   <= w_pre_pc_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_pc_out <= PC_INIT;
      r_inst_out   <= '0;
      r_rsh        <= 1'b0;
    end else begin
      r_rsh <= w_fill;
      if (w_fill) begin
        r_pre_pc_out <= r_pre_pc;
        r_inst_out   <= bus.bus_rdata;
      end
    end
  end

  assign o_pre_pc_out       = r_pre_pc_out;
  assign o_inst_out         = r_inst_out;
  assign o_read_shake_hands = r_rsh;

`ifdef PREPC_PERF_CNT_EN
  logic [31:0] r_fill_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt     <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_fill)     r_fill_cnt     <= r_fill_cnt + 32'd1;
      if (w_redirect) r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign o_fill_cnt     = r_fill_cnt;
  assign o_redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pre_pc_fetch.sv
// Directed bench for pre_pc_fetch: bus slave model with programmable read latency.
module tb_pre_pc_fetch;
  localparam logic [63:0] PC_INIT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc_in = '0;
  logic        jump_flag = 1'b0;
  logic [63:0] jump_addr = '0;
  logic        cache_full = 1'b0;
  logic        cache_missing = 1'b0;
  logic [63:0] pre_pc_out;
  logic [31:0] inst_out;
  logic        rsh;
`ifdef PREPC_PERF_CNT_EN
  logic [31:0] fill_cnt;
  logic [31:0] redirect_cnt;
`endif

  logic gnt_en = 1'b1;
  int   lat = 1;

  int nchk = 0;
  int nerr = 0;

  pre_pc_fetch_if #(.ADDR_W(64), .INST_W(32)) bus_if ();

  pre_pc_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus_if.master),
    .i_pc_in            (pc_in),
    .i_jump_flag        (jump_flag),
    .i_jump_addr        (jump_addr),
    .i_cache_full       (cache_full),
    .i_cache_missing    (cache_missing),
    .o_pre_pc_out       (pre_pc_out),
    .o_inst_out         (inst_out),
`ifdef PREPC_PERF_CNT_EN
    .o_fill_cnt         (fill_cnt),
    .o_redirect_cnt     (redirect_cnt),
`endif
    .o_read_shake_hands (rsh)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // Bus slave: one outstanding read, data returned `lat` cycles after grant.
  logic        pend;
  int          lcnt;
  logic [63:0] paddr;
  assign bus_if.bus_gnt = gnt_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend              <= 1'b0;
      lcnt              <= 0;
      paddr             <= '0;
      bus_if.bus_rvalid <= 1'b0;
      bus_if.bus_rdata  <= '0;
    end else begin
      bus_if.bus_rvalid <= 1'b0;
      if (pend) begin
        if (lcnt <= 1) begin
          bus_if.bus_rvalid <= 1'b1;
          bus_if.bus_rdata  <= mk(paddr);
          pend              <= 1'b0;
        end else begin
          lcnt <= lcnt - 1;
        end
      end else if (bus_if.bus_req && bus_if.bus_gnt) begin
        if (lat <= 1) begin
          bus_if.bus_rvalid <= 1'b1;
          bus_if.bus_rdata  <= mk(bus_if.bus_addr);
        end else begin
          pend  <= 1'b1;
          lcnt  <= lat - 1;
          paddr <= bus_if.bus_addr;
        end
      end
    end
  end

  // Fill-port collector
  logic [63:0] cap_addr [0:255];
  logic [31:0] cap_inst [0:255];
  int          nstrb = 0;
  always @(negedge clk) begin
    if (rsh && nstrb < 256) begin
      cap_addr[nstrb] <= pre_pc_out;
      cap_inst[nstrb] <= inst_out;
      nstrb           <= nstrb + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strb(input int target, input string tag);
    int k = 0;
    while (nstrb < target && k < 1000) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 64'(nstrb >= target), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int b;
    logic [63:0] a;

    // Reset state
    tick();
    check("rst_req", 64'(bus_if.bus_req), 64'd0);
    check("rst_addr", bus_if.bus_addr, PC_INIT);
    check("rst_prepc_out", pre_pc_out, PC_INIT);
    check("rst_inst", 64'(inst_out), 64'd0);
    check("rst_rsh", 64'(rsh), 64'd0);
`ifdef PREPC_PERF_CNT_EN
    check("rst_fill_cnt", 64'(fill_cnt), 64'd0);
`endif

    // Full burst from PC_INIT
    rst = 1'b0;
    tick();
    check("idle_to_req", 64'(bus_if.bus_req), 64'd1);
    wait_strb(16, "burst1");
    for (int i = 0; i < 16; i++) begin
      a = PC_INIT + 64'(4 * i);
      check($sformatf("b1_addr%0d", i), cap_addr[i], a);
      check($sformatf("b1_inst%0d", i), 64'(cap_inst[i]), 64'(mk(a)));
    end
    repeat (4) tick();
    check("b1_no17", 64'(nstrb), 64'd16);
    check("b1_full_req", 64'(bus_if.bus_req), 64'd0);
    check("b1_full_addr", bus_if.bus_addr, 64'h8000_0040);
`ifdef PREPC_PERF_CNT_EN
    check("b1_fill_cnt", 64'(fill_cnt), 64'd16);
    check("b1_redir_cnt", 64'(redirect_cnt), 64'd0);
`endif

    // CacheMissing in FULL re-bases with low bits cleared
    b = nstrb;
    cache_missing = 1'b1;
    pc_in = 64'h8000_1006;
    tick();
    cache_missing = 1'b0;
    check("miss_req", 64'(bus_if.bus_req), 64'd1);
    check("miss_addr", bus_if.bus_addr, 64'h8000_1004);
    wait_strb(b + 16, "burst2");
    check("b2_first", cap_addr[b], 64'h8000_1004);
    check("b2_last", cap_addr[b + 15], 64'h8000_1040);
    repeat (3) tick();
    check("b2_full_req", 64'(bus_if.bus_req), 64'd0);
`ifdef PREPC_PERF_CNT_EN
    check("b2_redir_cnt", 64'(redirect_cnt), 64'd1);
`endif

    // CacheFull raised during the 5th word stops the burst
    b = nstrb;
    jump_flag = 1'b1;
    jump_addr = 64'h8000_0000;
    tick();
    jump_flag = 1'b0;
    wait_strb(b + 4, "cf_four");
    cache_full = 1'b1;
    repeat (6) tick();
    check("cf_count", 64'(nstrb - b), 64'd5);
    check("cf_fifth", cap_addr[b + 4], 64'h8000_0010);
    check("cf_req", 64'(bus_if.bus_req), 64'd0);
    check("cf_prepc", bus_if.bus_addr, 64'h8000_0014);
    cache_full = 1'b0;
    tick();
    check("cf_stays_full", 64'(bus_if.bus_req), 64'd0);

    // JumpFlag beats CacheMissing; then redirect in WAIT drains the stale read
    lat = 3;
    jump_flag = 1'b1;
    jump_addr = 64'h9000_0000;
    cache_missing = 1'b1;
    pc_in = 64'h8000_0100;
    tick();
    jump_flag = 1'b0;
    cache_missing = 1'b0;
    check("prio_req", 64'(bus_if.bus_req), 64'd1);
    check("prio_addr", bus_if.bus_addr, 64'h9000_0000);
    b = nstrb;
    tick();
    check("wait_req", 64'(bus_if.bus_req), 64'd0);
    jump_flag = 1'b1;
    jump_addr = 64'hA000_000B;
    tick();
    jump_flag = 1'b0;
    check("drain_req", 64'(bus_if.bus_req), 64'd0);
    check("drain_addr", bus_if.bus_addr, 64'hA000_0008);
    repeat (2) tick();
    check("drain_no_strb", 64'(nstrb - b), 64'd0);
    check("drain_rereq", 64'(bus_if.bus_req), 64'd1);
    check("drain_readdr", bus_if.bus_addr, 64'hA000_0008);
    wait_strb(b + 1, "resume");
    check("resume_addr", cap_addr[b], 64'hA000_0008);
    check("resume_inst", 64'(cap_inst[b]), 64'(mk(64'hA000_0008)));

    // Address wrap at the top of the space
    lat = 1;
    jump_flag = 1'b1;
    jump_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    jump_flag = 1'b0;
    b = nstrb;
    wait_strb(b + 1, "wrap");
    check("wrap_strb_addr", cap_addr[b], 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_strb_inst", 64'(cap_inst[b]), 64'h0000_0000_A5A5_FFFC);
    check("wrap_next_addr", bus_if.bus_addr, 64'd0);
    check("wrap_next_req", 64'(bus_if.bus_req), 64'd1);

    // Reset pulse while a read is outstanding
    lat = 3;
    tick();
    check("pre_rst_wait", 64'(bus_if.bus_req), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 64'(bus_if.bus_req), 64'd0);
    check("mid_rst_addr", bus_if.bus_addr, PC_INIT);
    check("mid_rst_prepc_out", pre_pc_out, PC_INIT);
    check("mid_rst_rsh", 64'(rsh), 64'd0);
`ifdef PREPC_PERF_CNT_EN
    check("mid_rst_fill_cnt", 64'(fill_cnt), 64'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_req", 64'(bus_if.bus_req), 64'd1);
    check("post_rst_addr", bus_if.bus_addr, PC_INIT);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
